// File: rtl/s_block.sv
// Single-port memory slave: accepts one request at a time, pulses ack_out, and returns read data under a hold-until-taken handshake.
// Optional S_BLOCK_WAIT_EN inserts WAIT_CYC wait cycles between acceptance and acknowledge.
module s_block #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              c,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              master_in,
    input  logic              data_read,
    output logic              ack_out,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              master_out,
    output logic [1:0]        resp_stat
);

    // Handshake: req is sampled only in IDLE. ack_out is a one-cycle pulse.
    // rdata_valid stays high, with rdata stable, until data_read is seen in RDATA.
    localparam int DEPTH = 2 ** ADDR_W;

    // The encoding doubles as the resp_stat code, so the state is directly observable.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_RDATA = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                cmd_q;
    logic                master_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ack_q;
    logic                valid_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                cur_cmd;
    logic [ADDR_W-1:0]   cur_addr;

`ifdef S_BLOCK_WAIT_EN
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    assign accept = (state_q == ST_IDLE) && req;

    // On the accepting edge the latches are not yet loaded, so use the live inputs.
    assign cur_cmd  = accept ? c    : cmd_q;
    assign cur_addr = accept ? addr : addr_q;

    always_comb begin
        state_d = state_q;
`ifdef S_BLOCK_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
`ifdef S_BLOCK_WAIT_EN
                    if (WAIT_CYC == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYC - 1);
                    end
`else
                    state_d = ST_ACK;
`endif
                end
            end
            ST_WAIT: begin
`ifdef S_BLOCK_WAIT_EN
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ACK: begin
                state_d = cmd_q ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                if (data_read) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= 1'b0;
            master_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ST_ACK);
            valid_q <= (state_d == ST_RDATA);
            if (accept) begin
                cmd_q    <= c;
                addr_q   <= addr;
                wdata_q  <= wdata;
                master_q <= master_in;
            end
            // The write commits on the edge that leaves ACK.
            if (state_q == ST_ACK && cmd_q) begin
                mem_q[addr_q] <= wdata_q;
            end
            if (state_d == ST_ACK && !cur_cmd) begin
                rdata_q <= mem_q[cur_addr];
            end
        end
    end

`ifdef S_BLOCK_WAIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign ack_out     = ack_q;
    assign rdata       = rdata_q;
    assign rdata_valid = valid_q;
    assign master_out  = master_q;
    assign resp_stat   = state_q;

endmodule
